// File: rtl/end_screen_ctrl_if.sv
// Bundle between the game core and the end-of-game banner controller.
// The controller takes the slave side; the game core drives the master side.
interface end_screen_ctrl_if;
    logic        startOfFrame;
    logic [1:0]  lives;
    logic        restartKey;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        bannerEnable;
    logic        gameFreeze;
    logic        restartPulse;
    logic [2:0]  state;

    modport master (
        output startOfFrame, lives, restartKey,
        input  topLeftX, topLeftY, bannerEnable,
        input  gameFreeze, restartPulse, state
    );

    modport slave (
        input  startOfFrame, lives, restartKey,
        output topLeftX, topLeftY, bannerEnable,
        output gameFreeze, restartPulse, state
    );
endinterface

// File: rtl/end_screen_ctrl.sv
// Game-over banner: drop, hold, wait for restart key, issue restart pulse.
// Define END_SCREEN_BLINK_EN to blink the banner while waiting for the key.
module end_screen_ctrl #(
    parameter logic [10:0] BANNER_X     = 11'd304,
    parameter logic [10:0] START_Y      = 11'd0,
    parameter logic [10:0] FINAL_Y      = 11'd224,
    parameter logic [10:0] SLIDE_STEP   = 11'd8,
    parameter logic [7:0]  HOLD_FRAMES  = 8'd60,
    parameter logic [7:0]  BLINK_FRAMES = 8'd15
) (
    input  logic clk,
    input  logic resetN,
    end_screen_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_PLAY    = 3'd0,
        S_DROP    = 3'd1,
        S_HOLD    = 3'd2,
        S_WAIT    = 3'd3,
        S_RESTART = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST =
        (HOLD_FRAMES == 8'd0) ? 8'd0 : HOLD_FRAMES - 8'd1;

    state_t      r_state;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic        r_en;
    logic        r_frz;
    logic        r_pulse;
    logic [7:0]  r_hold;
    logic        r_key_prev;
    logic        r_guard;

`ifdef END_SCREEN_BLINK_EN
    localparam logic [7:0] BLINK_LAST =
        (BLINK_FRAMES == 8'd0) ? 8'd0 : BLINK_FRAMES - 8'd1;
    logic [7:0]  r_blink;
`endif

    logic [11:0] w_sum;
    logic        w_land;
    logic        w_key_rise;

    assign w_sum      = {1'b0, r_y} + {1'b0, SLIDE_STEP};
    assign w_land     = (w_sum >= {1'b0, FINAL_Y});
    assign w_key_rise = bus.restartKey & ~r_key_prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_PLAY;
            r_x        <= BANNER_X;
            r_y        <= START_Y;
            r_en       <= 1'b0;
            r_frz      <= 1'b0;
            r_pulse    <= 1'b0;
            r_hold     <= 8'd0;
            r_key_prev <= 1'b0;
            r_guard    <= 1'b0;
`ifdef END_SCREEN_BLINK_EN
            r_blink    <= 8'd0;
`endif
        end else begin
            r_key_prev <= bus.restartKey;
            r_x        <= BANNER_X;
            r_pulse    <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    r_en  <= 1'b0;
                    r_frz <= 1'b0;
                    if (bus.startOfFrame)
                        r_guard <= 1'b0;
                    // guard masks a stale lives==0 until the core reinits
                    if (bus.lives == 2'd0 && !r_guard) begin
                        r_state <= S_DROP;
                        r_y     <= START_Y;
                        r_en    <= 1'b1;
                        r_frz   <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (bus.startOfFrame) begin
                        if (w_land) begin
                            r_y     <= FINAL_Y;
                            r_state <= S_HOLD;
                            r_hold  <= 8'd0;
                        end else begin
                            r_y <= w_sum[10:0];
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.startOfFrame) begin
                        if (r_hold == HOLD_LAST) begin
                            r_state <= S_WAIT;
                            r_en    <= 1'b1;
`ifdef END_SCREEN_BLINK_EN
                            r_blink <= 8'd0;
`endif
                        end else begin
                            r_hold <= r_hold + 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_key_rise) begin
                        r_state <= S_RESTART;
                        r_pulse <= 1'b1;
                        r_en    <= 1'b0;
                        r_frz   <= 1'b1;
                    end
`ifdef END_SCREEN_BLINK_EN
                    else if (bus.startOfFrame) begin
                        if (r_blink == BLINK_LAST) begin
                            r_blink <= 8'd0;
                            r_en    <= ~r_en;
                        end else begin
                            r_blink <= r_blink + 8'd1;
                        end
                    end
`else
                    else begin
                        r_en <= 1'b1;
                    end
`endif
                end
                S_RESTART: begin
                    r_state <= S_PLAY;
                    r_y     <= START_Y;
                    r_en    <= 1'b0;
                    r_frz   <= 1'b0;
                    r_hold  <= 8'd0;
                    r_guard <= 1'b1;
`ifdef END_SCREEN_BLINK_EN
                    r_blink <= 8'd0;
`endif
                end
                default: begin
                    r_state <= S_PLAY;
                    r_y     <= START_Y;
                    r_en    <= 1'b0;
                    r_frz   <= 1'b0;
                    r_guard <= 1'b0;
                end
            endcase
        end
    end

    assign bus.topLeftX     = r_x;
    assign bus.topLeftY     = r_y;
    assign bus.bannerEnable = r_en;
    assign bus.gameFreeze   = r_frz;
    assign bus.restartPulse = r_pulse;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Scoreboard bench for end_screen_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_end_screen_ctrl;

    logic clk;
    logic resetN;

    end_screen_ctrl_if bus();

    end_screen_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [10:0] y;
        logic        en;
        logic        frz;
        logic        pul;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    checks   = 0;
    int    failures = 0;

    exp_t  m_e;
    exp_t  m_a;
    string m_n;

    always @(negedge clk) begin
        while (q_exp.size() > 0) begin
            m_e = q_exp.pop_front();
            m_n = q_name.pop_front();
            m_a = '{bus.state, bus.topLeftY, bus.bannerEnable,
                    bus.gameFreeze, bus.restartPulse};
            checks++;
            if (m_a !== m_e || bus.topLeftX !== 11'd304) begin
                failures++;
                $display("FAIL %s: got st=%0d y=%0d en=%b frz=%b pul=%b x=%0d, want st=%0d y=%0d en=%b frz=%b pul=%b x=304",
                         m_n, m_a.st, m_a.y, m_a.en, m_a.frz, m_a.pul,
                         bus.topLeftX, m_e.st, m_e.y, m_e.en, m_e.frz,
                         m_e.pul);
            end
        end
    end

    task automatic push(input string n, input logic [2:0] st,
                        input logic [10:0] y, input logic en,
                        input logic frz, input logic pul);
        exp_t e;
        e = '{st, y, en, frz, pul};
        q_exp.push_back(e);
        q_name.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    function automatic logic blink_en(input int k);
`ifdef END_SCREEN_BLINK_EN
        return ((k / 15) % 2) == 0;
`else
        return (k >= 0);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.lives        = 2'd3;
        bus.restartKey   = 1'b0;
        repeat (3) tick();
        push("reset", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        tick();
        push("play_idle", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        frame();
        push("play_sof", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        tick();

        bus.lives = 2'd0;
        tick();
        push("enter_drop", 3'd1, 11'd0, 1'b1, 1'b1, 1'b0);
        bus.lives = 2'd3;
        for (int k = 1; k <= 10; k++) begin
            frame();
            push("drop_step", 3'd1, 11'(8 * k), 1'b1, 1'b1, 1'b0);
            tick();
        end

        resetN = 1'b0;
        #1;
        push("reset_mid_drop", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        tick();
        push("reset_held", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        resetN = 1'b1;
        tick();
        push("play_after_reset", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);

        bus.lives = 2'd0;
        tick();
        push("enter_drop2", 3'd1, 11'd0, 1'b1, 1'b1, 1'b0);
        bus.lives = 2'd3;
        for (int k = 1; k <= 28; k++) begin
            frame();
            if (k < 28)
                push("drop_step2", 3'd1, 11'(8 * k), 1'b1, 1'b1, 1'b0);
            else
                push("drop_land", 3'd2, 11'd224, 1'b1, 1'b1, 1'b0);
            tick();
        end

        bus.restartKey = 1'b1;
        tick();
        bus.restartKey = 1'b0;
        tick();
        push("hold_key_ignored", 3'd2, 11'd224, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            if (k == 58)
                bus.restartKey = 1'b1;
            frame();
            if (k < 60)
                push("hold_count", 3'd2, 11'd224, 1'b1, 1'b1, 1'b0);
            else
                push("enter_wait", 3'd3, 11'd224, 1'b1, 1'b1, 1'b0);
            tick();
        end

        for (int k = 1; k <= 32; k++) begin
            frame();
            push("wait_key_held", 3'd3, 11'd224, blink_en(k), 1'b1, 1'b0);
            tick();
        end
        bus.restartKey = 1'b0;
        tick();
        push("wait_released", 3'd3, 11'd224, blink_en(32), 1'b1, 1'b0);

        bus.restartKey   = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        push("restart", 3'd4, 11'd224, 1'b0, 1'b1, 1'b1);
        bus.restartKey = 1'b0;
        bus.lives      = 2'd0;
        tick();
        push("play_after_restart", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        tick();
        push("guard_lives0", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        tick();
        push("guard_lives0_b", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        bus.lives = 2'd3;
        frame();
        push("guard_sof", 3'd0, 11'd0, 1'b0, 1'b0, 1'b0);
        bus.lives = 2'd0;
        tick();
        push("drop_after_guard", 3'd1, 11'd0, 1'b1, 1'b1, 1'b0);
        bus.lives = 2'd3;

        tick();
        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/end_screen_ctrl.md
END_SCREEN_CTRL -- requirements
Module: end_screen_ctrl

Interface
REQ-001 SHALL have parameter BANNER_X, default 11'd304, fixed banner top-left X.
REQ-002 SHALL have parameter START_Y, default 11'd0, banner top-left Y at drop start.
REQ-003 SHALL have parameter FINAL_Y, default 11'd224, banner resting Y; FINAL_Y >= START_Y.
REQ-004 SHALL have parameter SLIDE_STEP, default 11'd8, Y increment per frame while dropping.
REQ-005 SHALL have parameter HOLD_FRAMES, default 8'd60, frames restartKey is ignored after landing.
REQ-006 SHALL have parameter BLINK_FRAMES, default 8'd15, frames per blink half-period.
REQ-007 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-008 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port startOfFrame  input  1  one-clk pulse per VGA frame.
REQ-010 SHALL have port lives  input  2  remaining player lives.
REQ-011 SHALL have port restartKey  input  1  level from keypad, synchronous to clk.
REQ-012 SHALL have port topLeftX  output  11  banner square X.
REQ-013 SHALL have port topLeftY  output  11  banner square Y.
REQ-014 SHALL have port bannerEnable  output  1  gates banner drawing request.
REQ-015 SHALL have port gameFreeze  output  1  halts all game object motion.
REQ-016 SHALL have port restartPulse  output  1  one-clk game reinit command.
REQ-017 SHALL have port state  output  3  current FSM state code.

Function
REQ-018 SHALL implement states PLAY=0, DROP=1, HOLD=2, WAIT_KEY=3, RESTART=4; codes 5-7 SHALL go to PLAY next clk.
REQ-019 PLAY: bannerEnable=0, gameFreeze=0; lives==0 at a clk edge SHALL enter DROP next clk with topLeftY=START_Y; lives==0 SHALL be ignored until the first startOfFrame after entering PLAY from RESTART.
REQ-020 DROP: gameFreeze=1, bannerEnable=1; each startOfFrame SHALL add SLIDE_STEP to topLeftY; if the sum >= FINAL_Y (computed 12-bit, no wrap) topLeftY SHALL saturate to FINAL_Y and state SHALL go HOLD with frame counter cleared.
REQ-021 HOLD: gameFreeze=1, bannerEnable=1; restartKey ignored; frame counter SHALL increment per startOfFrame and enter WAIT_KEY on the startOfFrame where count reaches HOLD_FRAMES-1 (HOLD_FRAMES=0 treated as 1).
REQ-022 WAIT_KEY: gameFreeze=1; a rising edge of restartKey (registered previous value 0, current 1) SHALL enter RESTART next clk; a key already held on WAIT_KEY entry SHALL NOT trigger.
REQ-023 RESTART: restartPulse=1 for exactly one clk, gameFreeze=1, bannerEnable=0; next clk PLAY, topLeftY=START_Y, counters cleared.
REQ-024 restartPulse SHALL be 0 in every state except RESTART.
REQ-025 restartKey edge and startOfFrame on the same clk in WAIT_KEY: edge SHALL win; blink counter not updated.
REQ-026 topLeftX SHALL equal BANNER_X at all times after reset.
REQ-027 All outputs SHALL be registered; state-entry effects visible on the clk after the triggering edge.

Reset
REQ-028 resetN low SHALL immediately force state=PLAY, topLeftX=BANNER_X, topLeftY=START_Y, bannerEnable=0, gameFreeze=0, restartPulse=0, all counters and key-edge register to 0, from any state including mid-DROP.

Configuration
REQ-029 With END_SCREEN_BLINK_EN defined, WAIT_KEY SHALL toggle bannerEnable every BLINK_FRAMES startOfFrame pulses, starting at 1 on entry; without it bannerEnable SHALL stay 1 throughout WAIT_KEY and the blink counter SHALL not exist.

Verification
REQ-030 Reset asserted mid-DROP (topLeftY=80) -> same-cycle state=0, topLeftY=0, gameFreeze=0, bannerEnable=0.
REQ-031 lives 3->0 in PLAY -> next clk state=1, gameFreeze=1, bannerEnable=1, topLeftY=0; after 28 startOfFrame topLeftY=224, state=2.
REQ-032 restartKey pulsed during HOLD -> no RESTART; after 60 startOfFrame in HOLD state=3.
REQ-033 END_SCREEN_BLINK_EN defined, WAIT_KEY -> bannerEnable 1 for 15 frames, 0 for 15, 1 again; undefined -> constant 1.
REQ-034 restartKey rises on same clk as startOfFrame in WAIT_KEY -> state=4, restartPulse=1 for one clk, then state=0, topLeftY=0, gameFreeze=0.
REQ-035 restartKey held high across WAIT_KEY entry -> stays in WAIT_KEY until key released and pressed again.
